// File: rtl/side_road_sensor.sv
// side_road_sensor
//   Turns two raw side-road loop detectors into a vehicle queue count and a
//   registered service request (SENSOR) for the downstream light controller.
//   Each detector is synchronized (two flops), debounced, and edge-detected
//   (rising edge = one vehicle). A three-state request FSM asserts SENSOR
//   when the queue is long enough or a short queue has waited too long.
//
// Ports
//   clk          in   single clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   det_arrive   in   raw arrival loop detector (asynchronous)
//   det_exit     in   raw stop-line exit detector (asynchronous)
//   SENSOR       out  registered service request (1 exactly in REQ)
//   queue_count  out  registered number of waiting vehicles, 0..15
//   overflow     out  sticky: an arrival was dropped at count 15
module side_road_sensor #(
  parameter int DEBOUNCE_CYC = 4,   // 1..15
  parameter int ON_THRESH    = 3,
  parameter int OFF_THRESH   = 0,   // must be < ON_THRESH
  parameter int MAX_WAIT     = 30   // 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det_arrive,
  input  logic       det_exit,
  output logic       SENSOR,
  output logic [3:0] queue_count,
  output logic       overflow
);

  localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYC - 1);
  localparam logic [4:0] ON_T      = 5'(ON_THRESH);
  localparam logic [4:0] OFF_T     = 5'(OFF_THRESH);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2
  } state_t;

  // channel 0 = arrival, channel 1 = exit
  logic [1:0] raw;
  logic [1:0] event_pulse;

  assign raw = {det_exit, det_arrive};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic       sync1_reg;
      logic       sync2_reg;
      logic       level_reg;
      logic       level_prev_reg;
      logic [3:0] stable_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          stable_cnt_reg <= 4'd0;
        end else begin
          sync1_reg      <= raw[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level_reg;
          if (sync2_reg != level_reg) begin
            // this edge is the DEBOUNCE_CYC-th consecutive differing sample
            if (stable_cnt_reg == DEB_LAST) begin
              level_reg      <= sync2_reg;
              stable_cnt_reg <= 4'd0;
            end else begin
              stable_cnt_reg <= stable_cnt_reg + 4'd1;
            end
          end else begin
            stable_cnt_reg <= 4'd0;
          end
        end
      end

      // only rising debounced edges are vehicle events
      assign event_pulse[gi] = level_reg & ~level_prev_reg;
    end
  endgenerate

  logic       arrive_ev;
  logic       exit_ev;
  logic [3:0] count_next;
  logic       ovf_set;
  state_t     state_reg;
  state_t     state_next;
  logic [7:0] wait_timer_reg;
  logic       ge_on;
  logic       le_off;
  logic       timer_hit;

  assign arrive_ev = event_pulse[0];
  assign exit_ev   = event_pulse[1];

  // Saturating queue arithmetic; simultaneous events cancel.
  always_comb begin
    count_next = queue_count;
    ovf_set    = 1'b0;
    case ({arrive_ev, exit_ev})
      2'b10: begin
        if (queue_count == 4'd15) ovf_set = 1'b1;
        else                      count_next = queue_count + 4'd1;
      end
      2'b01: begin
        if (queue_count != 4'd0) count_next = queue_count - 4'd1;
      end
      default: count_next = queue_count;
    endcase
  end

  assign ge_on  = {1'b0, count_next} >= ON_T;
  assign le_off = {1'b0, count_next} <= OFF_T;
  // timer counts edges spent in WAIT; this edge would be the MAX_WAIT-th
  assign timer_hit = wait_timer_reg >= WAIT_LAST;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ge_on)                   state_next = REQ;
        else if (count_next != 4'd0) state_next = WAIT;
      end
      WAIT: begin
        if (ge_on || timer_hit)      state_next = REQ;
        else if (count_next == 4'd0) state_next = IDLE;
      end
      REQ: begin
        if (le_off) state_next = (count_next == 4'd0) ? IDLE : WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wait_timer_reg <= 8'd0;
      SENSOR         <= 1'b0;
      queue_count    <= 4'd0;
      overflow       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      SENSOR      <= (state_next == REQ);
      queue_count <= count_next;
      if (ovf_set) overflow <= 1'b1;
      if ((state_next != state_reg) || (state_next != WAIT))
        wait_timer_reg <= 8'd0;
      else if (wait_timer_reg != 8'hFF)
        wait_timer_reg <= wait_timer_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_side_road_sensor.sv
// Testbench for side_road_sensor: directed scenarios plus randomized detector
// activity, every cycle compared against a behavioural model of the queue.
module tb_side_road_sensor;
  localparam int DEB = 4;
  localparam int ON  = 3;
  localparam int OFF = 0;
  localparam int MW  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det_arrive = 1'b0;
  logic       det_exit = 1'b0;
  logic       SENSOR;
  logic [3:0] queue_count;
  logic       overflow;

  always #5 clk = ~clk;

  side_road_sensor #(
    .DEBOUNCE_CYC(DEB), .ON_THRESH(ON), .OFF_THRESH(OFF), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst), .det_arrive(det_arrive), .det_exit(det_exit),
    .SENSOR(SENSOR), .queue_count(queue_count), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: raw sample history per detector (index 0 newest),
  // debounced levels, pending rising edges, queue, request state.
  bit hist [2][20];
  bit lvl  [2];
  bit rose [2];
  int m_count;
  bit m_ovf;
  int m_state;   // 0 idle, 1 waiting, 2 requesting
  int m_wait;    // edges spent waiting since entering

  task automatic model_step(input bit a, input bit e, input bit r);
    bit arr, ex, flip;
    int nc;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 20; i++) hist[c][i] = 1'b0;
        lvl[c] = 1'b0;
        rose[c] = 1'b0;
      end
      m_count = 0; m_ovf = 1'b0; m_state = 0; m_wait = 0;
      return;
    end
    arr = rose[0];
    ex  = rose[1];
    for (int c = 0; c < 2; c++) begin
      // debouncer sees samples two edges old; flip once DEB of them differ
      flip = 1'b1;
      for (int i = 1; i <= DEB; i++) if (hist[c][i] == lvl[c]) flip = 1'b0;
      rose[c] = flip && !lvl[c];
      if (flip) lvl[c] = !lvl[c];
      for (int i = 19; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = (c == 0) ? a : e;
    end
    nc = m_count;
    if (arr && !ex) begin
      if (nc == 15) m_ovf = 1'b1; else nc = nc + 1;
    end else if (ex && !arr && nc > 0) begin
      nc = nc - 1;
    end
    m_count = nc;
    case (m_state)
      0: begin
        if (nc >= ON) m_state = 2;
        else if (nc > 0) begin m_state = 1; m_wait = 0; end
      end
      1: begin
        if (nc >= ON || m_wait + 1 >= MW) m_state = 2;
        else if (nc == 0) m_state = 0;
        else m_wait = m_wait + 1;
      end
      default: begin
        if (nc <= OFF) begin
          m_state = (nc == 0) ? 0 : 1;
          m_wait = 0;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit a, input bit e, input bit r);
    det_arrive = a; det_exit = e; rst = r;
    @(posedge clk);
    model_step(a, e, r);
    #1;
    check_eq("queue_count", int'(queue_count), m_count);
    check_eq("SENSOR", int'(SENSOR), (m_state == 2) ? 1 : 0);
    check_eq("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic pulse(input bit a, input bit e);
    repeat (6) cycle(a, e, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    check_eq("reset_count", int'(queue_count), 0);
    check_eq("reset_sensor", int'(SENSOR), 0);
    check_eq("reset_overflow", int'(overflow), 0);

    // glitch shorter than the debounce window
    repeat (3) cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);
    check_eq("short_pulse_count", int'(queue_count), 0);

    // three clean arrivals raise the request
    repeat (3) pulse(1, 0);
    check_eq("three_arr_count", int'(queue_count), 3);
    check_eq("three_arr_sensor", int'(SENSOR), 1);

    // three exits drain the queue
    repeat (3) pulse(0, 1);
    check_eq("drain_count", int'(queue_count), 0);
    check_eq("drain_sensor", int'(SENSOR), 0);

    // single waiting vehicle forces the request by timeout
    repeat (6) cycle(1, 0, 0);
    repeat (45) cycle(0, 0, 0);
    check_eq("timeout_sensor", int'(SENSOR), 1);
    check_eq("timeout_count", int'(queue_count), 1);
    pulse(0, 1);

    // saturation and overflow, then simultaneous events at 15
    repeat (17) pulse(1, 0);
    check_eq("sat_count", int'(queue_count), 15);
    check_eq("sat_overflow", int'(overflow), 1);
    pulse(1, 1);
    check_eq("simul_count", int'(queue_count), 15);
    check_eq("simul_overflow", int'(overflow), 1);

    // randomized detector activity
    for (int k = 0; k < 200; k++) begin
      bit a, e;
      int len;
      a = 1'($urandom_range(0, 1));
      e = (k % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      repeat (len) cycle(a, e, 1'b0);
    end

    // reset mid-operation with a debounce in progress
    cycle(0, 0, 1);
    repeat (5) pulse(1, 0);
    check_eq("pre_reset_count", int'(queue_count), 5);
    repeat (2) cycle(1, 0, 0);
    cycle(1, 0, 1);
    check_eq("mid_reset_count", int'(queue_count), 0);
    check_eq("mid_reset_sensor", int'(SENSOR), 0);
    check_eq("mid_reset_overflow", int'(overflow), 0);
    repeat (DEB + 2) cycle(1, 0, 0);
    check_eq("rereg_before", int'(queue_count), 0);
    cycle(1, 0, 0);
    check_eq("rereg_count", int'(queue_count), 1);
    repeat (10) cycle(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
